// File: rtl/tri_transform.sv
// tri_transform: applies a 4x4 signed fixed-point matrix to the three vertices
// of a triangle, one output row per cycle (x, y, z, then w).
// Input w is always taken as 1.0, so mat_in[*][0] acts as a translation column.
// Optional feature: define TRI_TRANSFORM_SATURATE_EN to clamp each result to
// the signed 32-bit range instead of keeping the low 32 bits.
//
// Handshake: a triangle is taken on a rising edge where valid_in && ready_out.
// ready_out is high only in IDLE; valid_in seen while busy is discarded and
// latches dropped_out. valid_out is a single-cycle pulse with no back-pressure.
// obj_done_out is only ever high together with valid_out.
module tri_transform #(
  parameter int FRAC_BITS = 16
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic [3:0][2:0][31:0] tri_in,
  input  logic                  valid_in,
  input  logic                  obj_done_in,
  input  logic [3:0][3:0][31:0] mat_in,
  output logic                  ready_out,
  output logic [3:0][2:0][31:0] tri_out,
  output logic                  valid_out,
  output logic                  obj_done_out,
  output logic                  dropped_out,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] ONE = 32'd1 << FRAC_BITS;

`ifdef TRI_TRANSFORM_SATURATE_EN
  localparam logic signed [65:0] SAT_MAX = 66'sh0_7FFF_FFFF;
  localparam logic signed [65:0] SAT_MIN = -66'sh0_8000_0000;
`endif

  state_t                state_q, state_d;
  logic [1:0]            row_q;
  logic [3:0][2:0][31:0] tri_q;
  logic [3:0][3:0][31:0] mat_q;
  logic                  obj_done_q;
  logic                  accept;
  logic                  last_row;

  logic [63:0]           prod;
  logic signed [65:0]    acc [3];
  logic [31:0]           res [3];
`ifdef TRI_TRANSFORM_SATURATE_EN
  logic signed [65:0]    shifted [3];
`endif

  // Sign-extend both operands to 64 bits so the product is the full signed result.
  function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] ea;
    logic signed [63:0] eb;
    ea = $signed({{32{a[31]}}, a});
    eb = $signed({{32{b[31]}}, b});
    smul = ea * eb;
  endfunction

  assign ready_out = (state_q == IDLE);
  assign accept    = valid_in && ready_out;
  assign last_row  = (state_q == CALC) && (row_q == 2'd0);
  assign state_dbg = state_q;

  // Next-state logic: IDLE -> CALC on accept, four CALC cycles, one DONE cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC:    if (row_q == 2'd0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register and row counter; the counter wraps 0 -> 3 as CALC ends.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      row_q   <= 2'd3;
    end else begin
      state_q <= state_d;
      if (accept) begin
        row_q <= 2'd3;
      end else if (state_q == CALC) begin
        row_q <= row_q - 2'd1;
      end
    end
  end

  // Capture the triangle, matrix and end-of-object flag on accept.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tri_q      <= '0;
      mat_q      <= '0;
      obj_done_q <= 1'b0;
    end else if (accept) begin
      tri_q      <= tri_in;
      mat_q      <= mat_in;
      obj_done_q <= obj_done_in;
    end
  end

  // Dot product of the current matrix row with each vertex (w forced to 1.0).
  always_comb begin
    prod = '0;
    for (int v = 0; v < 3; v++) begin
      acc[v] = '0;
      for (int j = 0; j < 4; j++) begin
        prod   = smul(mat_q[row_q][j], (j == 0) ? ONE : tri_q[j][v]);
        acc[v] = acc[v] + {{2{prod[63]}}, prod};
      end
`ifdef TRI_TRANSFORM_SATURATE_EN
      shifted[v] = acc[v] >>> FRAC_BITS;
      if (shifted[v] > SAT_MAX) begin
        res[v] = 32'h7FFF_FFFF;
      end else if (shifted[v] < SAT_MIN) begin
        res[v] = 32'h8000_0000;
      end else begin
        res[v] = shifted[v][31:0];
      end
`else
      res[v] = 32'(acc[v] >>> FRAC_BITS);
`endif
    end
  end

  // Output registers: one row written per CALC cycle, result pulse after the last row.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tri_out      <= '0;
      valid_out    <= 1'b0;
      obj_done_out <= 1'b0;
    end else begin
      valid_out    <= last_row;
      obj_done_out <= last_row && obj_done_q;
      if (state_q == CALC) begin
        for (int v = 0; v < 3; v++) begin
          tri_out[row_q][v] <= res[v];
        end
      end
    end
  end

  // Sticky record of any triangle offered while busy; cleared only by reset.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      dropped_out <= 1'b0;
    end else if (valid_in && !ready_out) begin
      dropped_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tri_transform.sv
// Bench for tri_transform: directed triangles with hand-computed results.
// Drivers push {obj_done, tri} and the handshake cycle into queues; a monitor
// on the falling edge pops and compares whenever valid_out is high.
// Honours TRI_TRANSFORM_SATURATE_EN for the overflow vectors.
module tb_tri_transform;

  typedef logic [3:0][2:0][31:0] tri_t;
  typedef logic [3:0][3:0][31:0] mat_t;
  localparam int W = 385;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  tri_t        tri_in;
  logic        valid_in;
  logic        obj_done_in;
  mat_t        mat_in;
  logic        ready_out;
  tri_t        tri_out;
  logic        valid_out;
  logic        obj_done_out;
  logic        dropped_out;
  logic [1:0]  state_dbg;

  logic [W-1:0] exp_q[$];
  int           stamp_q[$];
  int           cyc = 0;
  int           n_cmp = 0;
  int           n_bad = 0;
  int           last_acc = 0;
  int           gap = 0;
  logic [W-1:0] mon_e;
  int           mon_c;

  tri_transform #(.FRAC_BITS(16)) dut (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .tri_in       (tri_in),
    .valid_in     (valid_in),
    .obj_done_in  (obj_done_in),
    .mat_in       (mat_in),
    .ready_out    (ready_out),
    .tri_out      (tri_out),
    .valid_out    (valid_out),
    .obj_done_out (obj_done_out),
    .dropped_out  (dropped_out),
    .state_dbg    (state_dbg)
  );

  // Clock and cycle counter
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic tri_t mk(input logic [31:0] x0, x1, x2, y0, y1, y2,
                              z0, z1, z2, w0, w1, w2);
    tri_t t;
    t[3][0] = x0; t[3][1] = x1; t[3][2] = x2;
    t[2][0] = y0; t[2][1] = y1; t[2][2] = y2;
    t[1][0] = z0; t[1][1] = z1; t[1][2] = z2;
    t[0][0] = w0; t[0][1] = w1; t[0][2] = w2;
    return t;
  endfunction

  function automatic mat_t diag(input logic [31:0] d);
    mat_t m = '0;
    for (int i = 0; i < 4; i++) m[i][i] = d;
    return m;
  endfunction

  // Drive one triangle this cycle; optionally record the expected response.
  task automatic present(input tri_t t, input mat_t m, input logic od,
                         input logic [W-1:0] e, input bit push);
    tri_in      = t;
    mat_in      = m;
    obj_done_in = od;
    valid_in    = 1'b1;
    gap         = cyc - last_acc;
    last_acc    = cyc;
    if (push) begin
      exp_q.push_back(e);
      stamp_q.push_back(cyc);
    end
  endtask

  // Wait (bounded) for ready_out, then offer the triangle for one cycle.
  task automatic send(input tri_t t, input mat_t m, input logic od,
                      input logic [W-1:0] e, input bit push);
    int n = 0;
    @(negedge clk_in);
    while (!ready_out && n < 20) begin
      @(negedge clk_in);
      n++;
    end
    if (!ready_out) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout: ready_out=0 after %0d cycles, required 1", n);
    end
    present(t, m, od, e, push);
    @(negedge clk_in);
    valid_in = 1'b0;
  endtask

  // Bounded wait for the scoreboard to empty, plus slack to catch stray pulses.
  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk_in);
      n++;
    end
    check("drain_pending", W'(exp_q.size()), W'(0));
    repeat (4) @(negedge clk_in);
  endtask

  // Monitor: compare every result pulse; obj_done_out must be low otherwise.
  always @(negedge clk_in) begin
    if (rst_n_in === 1'b1) begin
      if (valid_out) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_valid: valid_out=1 at cycle %0d, required 0", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          mon_c = stamp_q.pop_front();
          check("result", {obj_done_out, tri_out}, mon_e);
          check("latency", W'(cyc - mon_c), W'(5));
        end
      end else begin
        check("obj_done_idle", W'(obj_done_out), W'(0));
      end
    end
  end

  tri_t t_id, t_tr, t_sat, t_gen, e_id, e_tr, e_sat, e_gen;
  mat_t m_id, m_tr, m_sat, m_gen;
  logic [31:0] sx0, sx1;

  initial begin
    rst_n_in    = 1'b0;
    valid_in    = 1'b0;
    obj_done_in = 1'b0;
    tri_in      = '0;
    mat_in      = '0;

    // Identity: x,y,z pass through, w becomes 1.0 regardless of input w.
    m_id = diag(32'h0001_0000);
    t_id = mk(32'h0001_0000, 32'h0004_0000, 32'h0007_0000,
              32'h0002_0000, 32'h0005_0000, 32'h0008_0000,
              32'h0003_0000, 32'h0006_0000, 32'h0009_0000,
              32'hDEAD_BEEF, 32'h1234_5678, 32'h8000_0001);
    e_id = mk(32'h0001_0000, 32'h0004_0000, 32'h0007_0000,
              32'h0002_0000, 32'h0005_0000, 32'h0008_0000,
              32'h0003_0000, 32'h0006_0000, 32'h0009_0000,
              32'h0001_0000, 32'h0001_0000, 32'h0001_0000);

    // Translation by +5 in x.
    m_tr = diag(32'h0001_0000);
    m_tr[3][0] = 32'h0005_0000;
    t_tr = mk(32'h0001_0000, 32'h0001_0000, 32'h0001_0000,
              32'h0000_0001, 32'h0000_0002, 32'h0000_0003,
              32'hFFFF_8000, 32'hFFFF_8000, 32'hFFFF_8000,
              32'h0, 32'h0, 32'h0);
    e_tr = mk(32'h0006_0000, 32'h0006_0000, 32'h0006_0000,
              32'h0000_0001, 32'h0000_0002, 32'h0000_0003,
              32'hFFFF_8000, 32'hFFFF_8000, 32'hFFFF_8000,
              32'h0001_0000, 32'h0001_0000, 32'h0001_0000);

    // Scale by 2 with x overflowing both ways.
`ifdef TRI_TRANSFORM_SATURATE_EN
    sx0 = 32'h7FFF_FFFF;
    sx1 = 32'h8000_0000;
`else
    sx0 = 32'hFFFE_0000;
    sx1 = 32'h0000_0000;
`endif
    m_sat = diag(32'h0002_0000);
    t_sat = mk(32'h7FFF_0000, 32'h8000_0000, 32'h0001_0000,
               32'h0001_0000, 32'h0001_0000, 32'h0001_0000,
               32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000,
               32'h0, 32'h0, 32'h0);
    e_sat = mk(sx0, sx1, 32'h0002_0000,
               32'h0002_0000, 32'h0002_0000, 32'h0002_0000,
               32'hFFFE_0000, 32'hFFFE_0000, 32'hFFFE_0000,
               32'h0002_0000, 32'h0002_0000, 32'h0002_0000);

    // Mixed-sign general matrix; v2.y = -1 LSB checks floor rounding.
    m_gen = '0;
    m_gen[3][3] = 32'h0002_0000; m_gen[3][2] = 32'hFFFF_0000; m_gen[3][0] = 32'h0000_8000;
    m_gen[2][2] = 32'h0000_8000; m_gen[2][1] = 32'h0003_0000; m_gen[2][0] = 32'hFFFE_0000;
    m_gen[1][1] = 32'hFFFF_0000;
    m_gen[0][3] = 32'h0001_0000; m_gen[0][0] = 32'h0001_0000;
    t_gen = mk(32'h0001_0000, 32'hFFFE_8000, 32'h0000_0000,
               32'h0002_0000, 32'h0000_4000, 32'hFFFF_FFFF,
               32'h0003_0000, 32'hFFFC_0000, 32'h0000_0000,
               32'h5555_5555, 32'hAAAA_AAAA, 32'h7777_7777);
    e_gen = mk(32'h0000_8000, 32'hFFFD_4000, 32'h0000_8001,
               32'h0008_0000, 32'hFFF2_2000, 32'hFFFD_FFFF,
               32'hFFFD_0000, 32'h0004_0000, 32'h0000_0000,
               32'h0002_0000, 32'hFFFF_8000, 32'h0001_0000);

    // Reset state
    repeat (2) @(negedge clk_in);
    check("rst_tri_out", W'(tri_out), W'(0));
    check("rst_valid", W'(valid_out), W'(0));
    check("rst_obj_done", W'(obj_done_out), W'(0));
    check("rst_dropped", W'(dropped_out), W'(0));
    check("rst_ready", W'(ready_out), W'(1));
    rst_n_in = 1'b1;

    // Directed transforms
    send(t_id, m_id, 1'b0, {1'b0, e_id}, 1'b1);
    drain();
    send(t_tr, m_tr, 1'b0, {1'b0, e_tr}, 1'b1);
    drain();
    send(t_sat, m_sat, 1'b0, {1'b0, e_sat}, 1'b1);
    drain();
    send(t_gen, m_gen, 1'b1, {1'b1, e_gen}, 1'b1);
    drain();

    // Back-to-back at full rate: accepts 6 cycles apart
    send(t_gen, m_gen, 1'b0, {1'b0, e_gen}, 1'b1);
    send(t_id, m_id, 1'b1, {1'b1, e_id}, 1'b1);
    check("accept_gap", W'(gap), W'(6));
    drain();
    check("no_drop_yet", W'(dropped_out), W'(0));

    // Offer while busy: discarded, first result intact, sticky flag set
    send(t_tr, m_tr, 1'b0, {1'b0, e_tr}, 1'b1);
    @(negedge clk_in);
    present(t_sat, m_sat, 1'b1, '0, 1'b0);
    @(negedge clk_in);
    valid_in = 1'b0;
    drain();
    check("dropped_set", W'(dropped_out), W'(1));
    send(t_sat, m_sat, 1'b0, {1'b0, e_sat}, 1'b1);
    drain();
    check("dropped_sticky", W'(dropped_out), W'(1));

    // Reset during CALC aborts the triangle and clears outputs at once
    send(t_gen, m_gen, 1'b1, '0, 1'b0);
    check("mid_calc_state", W'(state_dbg), W'(1));
    #2 rst_n_in = 1'b0;
    #1;
    check("arst_tri_out", W'(tri_out), W'(0));
    check("arst_valid", W'(valid_out), W'(0));
    check("arst_dropped", W'(dropped_out), W'(0));
    check("arst_ready", W'(ready_out), W'(1));
    check("arst_state", W'(state_dbg), W'(0));
    @(negedge clk_in);
    // Release with a triangle already offered: taken on the first rising edge
    rst_n_in = 1'b1;
    present(t_tr, m_tr, 1'b1, {1'b1, e_tr}, 1'b1);
    @(negedge clk_in);
    valid_in = 1'b0;
    repeat (10) @(negedge clk_in);
    drain();
    check("dropped_after_rst", W'(dropped_out), W'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tri_transform.md
TRI_TRANSFORM -- requirements
Module: tri_transform

Interface
REQ-001 SHALL have parameter FRAC_BITS, default 16: number of fractional bits of the signed fixed-point format used by every coordinate and matrix element.
REQ-002 SHALL have port clk_in, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n_in, input, 1: reset; asynchronous assert, active-low.
REQ-004 SHALL have port tri_in [3:0][2:0], input, 32 each: triangle; row 3=x, 2=y, 1=z, 0=w; column = vertex 0..2.
REQ-005 SHALL have port valid_in, input, 1: tri_in and obj_done_in are valid this cycle.
REQ-006 SHALL have port obj_done_in, input, 1: this triangle is the last of the object.
REQ-007 SHALL have port mat_in [3:0][3:0], input, 32 each: transform matrix; mat_in[i][j] = output component i, input component j, same row numbering as tri_in.
REQ-008 SHALL have port ready_out, output, 1: the block can accept a triangle this cycle.
REQ-009 SHALL have port tri_out [3:0][2:0], output, 32 each: transformed triangle, same layout as tri_in.
REQ-010 SHALL have port valid_out, output, 1: tri_out is new this cycle.
REQ-011 SHALL have port obj_done_out, output, 1: the triangle on tri_out is the last of the object.
REQ-012 SHALL have port dropped_out, output, 1: sticky flag; a triangle was offered while the block was busy.

Function
REQ-013 SHALL implement states IDLE, CALC and DONE; ready_out = 1 only in IDLE.
REQ-014 SHALL accept when valid_in && ready_out; on accept, latch tri_in, mat_in and obj_done_in, clear the row counter to 3, and go to CALC.
REQ-015 SHALL ignore tri_in[0][*] and use 1.0 (1 << FRAC_BITS) as the input w of every vertex.
REQ-016 In CALC, each cycle SHALL compute output row r for all three vertices: out[r][v] = sum over j of mat[r][j]*tri[j][v].
REQ-017 SHALL form each product signed 64-bit, sum the four products at at least 66 bits, then arithmetically shift right by FRAC_BITS.
REQ-018 SHALL store each result into tri_out[r][v] after the range handling of REQ-030/REQ-031.
REQ-019 SHALL decrement r after each CALC cycle; after r = 0, SHALL go to DONE.
REQ-020 In DONE, SHALL assert valid_out for exactly one cycle with obj_done_out = the latched obj_done_in, then return to IDLE.
REQ-021 Latency: accept at cycle N produces valid_out at cycle N+5; maximum throughput is one triangle per 6 cycles.
REQ-022 tri_out SHALL hold its value between results; rows already written SHALL be updated during CALC.
REQ-023 valid_in while ready_out = 0 SHALL be discarded without disturbing the triangle in flight, and SHALL set dropped_out.
REQ-024 obj_done_out SHALL be 0 whenever valid_out = 0.

Reset
REQ-025 While rst_n_in = 0, SHALL immediately force state IDLE and r = 3.
REQ-026 While rst_n_in = 0, SHALL force tri_out = 0, valid_out = 0, obj_done_out = 0 and dropped_out = 0; ready_out SHALL be 1.
REQ-027 Reset in CALC or DONE SHALL abort the triangle; no valid_out for that triangle ever appears.
REQ-028 After reset release, SHALL accept valid_in on the first rising edge.
REQ-029 dropped_out SHALL clear only on reset.

Configuration
REQ-030 With macro TRI_TRANSFORM_SATURATE_EN defined, each shifted sum outside the signed 32-bit range SHALL clamp to 0x7FFFFFFF or 0x80000000.
REQ-031 Without TRI_TRANSFORM_SATURATE_EN, the low 32 bits SHALL be kept (two's-complement wrap) and no clamp logic SHALL exist.

Verification
REQ-032 Identity matrix (diagonal 0x00010000); vertices (1,2,3), (4,5,6), (7,8,9) in Q16.16 -> valid_out 5 cycles after accept; x,y,z unchanged; w = 0x00010000.
REQ-033 Identity matrix plus mat_in[3][0] = 0x00050000; vertex x = 0x00010000 -> tri_out[3][v] = 0x00060000 for every vertex.
REQ-034 Diagonal 0x00020000; x = 0x7FFF0000 -> 0x7FFFFFFF with SATURATE_EN; 0xFFFE0000 without it.
REQ-035 Second valid_in 2 cycles after accept -> the first result is correct, no second valid_out, dropped_out = 1 until reset.
REQ-036 obj_done_in = 1 with a triangle -> obj_done_out = 1 coincident with its valid_out only.
REQ-037 rst_n_in low for 1 cycle during CALC -> outputs zero immediately, no valid_out; the next triangle is accepted and correct.
